// File: rtl/scp_pkg.sv
// Shared types and constants for the breach escalator: FSM state encodings,
// decoded alert-level codes and the access-grant vector for each state.
package scp_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SECURITY = 3'd1,
        S_DATABASE = 3'd2,
        S_CONTROL  = 3'd3,
        S_COOLDOWN = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        LVL_GREEN   = 2'd0,
        LVL_YELLOW  = 2'd1,
        LVL_RED     = 2'd2,
        LVL_INVALID = 2'd3
    } level_e;

    // Grant vectors are ordered {control_sys, database, security}.
    localparam logic [2:0] GRANT_IDLE     = 3'b000;
    localparam logic [2:0] GRANT_SECURITY = 3'b001;
    localparam logic [2:0] GRANT_DATABASE = 3'b011;
    localparam logic [2:0] GRANT_CONTROL  = 3'b111;

    // COOLDOWN keeps presenting the grants of the level it left.
    function automatic logic [2:0] grants_of(input state_e s, input state_e ret);
        state_e eff;
        logic [2:0] g;
        eff = (s == S_COOLDOWN) ? ret : s;
        case (eff)
            S_SECURITY: g = GRANT_SECURITY;
            S_DATABASE: g = GRANT_DATABASE;
            S_CONTROL:  g = GRANT_CONTROL;
            default:    g = GRANT_IDLE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/scp_level_decode.sv
// Converts the one-hot {green,yellow,red} alert lines into a level code and a
// valid flag; anything other than exactly one bit set is invalid.
module scp_level_decode
    import scp_pkg::*;
(
    input  logic   green,
    input  logic   yellow,
    input  logic   red,
    output level_e level,
    output logic   valid
);

    // One-hot decode of the alert lines.
    always_comb begin
        level = LVL_INVALID;
        valid = 1'b0;
        case ({green, yellow, red})
            3'b100: begin level = LVL_GREEN;  valid = 1'b1; end
            3'b010: begin level = LVL_YELLOW; valid = 1'b1; end
            3'b001: begin level = LVL_RED;    valid = 1'b1; end
            default: begin level = LVL_INVALID; valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/scp_breach_escalator.sv
// Breach escalator: escalates access grants security -> database -> control
// on dwell thresholds, de-escalates through a green cooldown.
// Optional build macro SCP_CHEAT_EN enables the red-green-red cheat detector
// that forces the FSM back to IDLE; without it cheat_out is tied low.
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | no grants; yellow dwell counts toward security
// SECURITY   | security granted; yellow/red dwell counts toward database
// DATABASE   | security+database; dwell counts toward control
// CONTROL    | all grants; timer keeps a saturating dwell count
// COOLDOWN   | grants of ret_state; green run returns to IDLE
module scp_breach_escalator
    import scp_pkg::*;
#(
    parameter int TIMER_W = 8,
    parameter int T_SEC   = 5,
    parameter int T_DB    = 10,
    parameter int T_CTRL  = 20,
    parameter int T_COOL  = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               green,
    input  logic               yellow,
    input  logic               red,
    output logic               a_security,
    output logic               a_database,
    output logic               a_control_sys,
    output logic               cheat_out,
    output logic               fault,
    output logic [2:0]         state,
    output logic [TIMER_W-1:0] timer
);

    localparam logic [TIMER_W-1:0] TIMER_MAX = {TIMER_W{1'b1}};
    localparam logic [TIMER_W-1:0] TH_SEC    = TIMER_W'(T_SEC);
    localparam logic [TIMER_W-1:0] TH_DB     = TIMER_W'(T_DB);
    localparam logic [TIMER_W-1:0] TH_CTRL   = TIMER_W'(T_CTRL);
    localparam logic [TIMER_W-1:0] TH_COOL   = TIMER_W'(T_COOL);
    localparam logic [TIMER_W:0]   INC_ONE   = (TIMER_W+1)'(1);
    localparam logic [TIMER_W:0]   INC_RED   = (TIMER_W+1)'(2);

    level_e             level;
    logic               valid;
    state_e             state_q, nxt_state;
    state_e             ret_q, nxt_ret;
    logic [TIMER_W-1:0] timer_q, nxt_timer;
    logic [TIMER_W-1:0] dwell_sat, cool_sat;
    logic [TIMER_W:0]   dwell_sum, cool_sum, inc;
    logic [2:0]         grants_q;
    logic               fault_q;
    logic               cheat_hit;

    scp_level_decode u_decode (
        .green  (green),
        .yellow (yellow),
        .red    (red),
        .level  (level),
        .valid  (valid)
    );

`ifdef SCP_CHEAT_EN
    level_e [1:0] hist_lvl_q;
    logic   [1:0] hist_v_q;
    logic         cheat_q;

    assign cheat_hit = valid && (level == LVL_RED)
                     && hist_v_q[0] && (hist_lvl_q[0] == LVL_GREEN)
                     && hist_v_q[1] && (hist_lvl_q[1] == LVL_RED);

    // History of the last two valid levels; an invalid cycle breaks the run.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hist_v_q   <= 2'b00;
            hist_lvl_q <= {LVL_GREEN, LVL_GREEN};
            cheat_q    <= 1'b0;
        end else begin
            cheat_q <= cheat_hit;
            if (valid) begin
                hist_v_q   <= {hist_v_q[0], 1'b1};
                hist_lvl_q <= {hist_lvl_q[0], level};
            end else begin
                hist_v_q <= 2'b00;
            end
        end
    end

    assign cheat_out = cheat_q;
`else
    assign cheat_hit = 1'b0;
    assign cheat_out = 1'b0;
`endif

    // Next-state, dwell timer and return-level selection.
    always_comb begin
        nxt_state = state_q;
        nxt_ret   = ret_q;
        nxt_timer = timer_q;
        inc       = (level == LVL_RED) ? INC_RED : INC_ONE;
        dwell_sum = {1'b0, timer_q} + inc;
        dwell_sat = dwell_sum[TIMER_W] ? TIMER_MAX : dwell_sum[TIMER_W-1:0];
        cool_sum  = {1'b0, timer_q} + INC_ONE;
        cool_sat  = cool_sum[TIMER_W] ? TIMER_MAX : cool_sum[TIMER_W-1:0];

        if (state_q > S_COOLDOWN) begin
            nxt_state = S_IDLE;
            nxt_ret   = S_IDLE;
            nxt_timer = '0;
        end else if (valid) begin
            case (state_q)
                S_IDLE: begin
                    if (level == LVL_GREEN) begin
                        nxt_timer = '0;
                    end else if (level == LVL_RED) begin
                        nxt_state = S_SECURITY;
                        nxt_timer = '0;
                    end else if (dwell_sat >= TH_SEC) begin
                        nxt_state = S_SECURITY;
                        nxt_timer = '0;
                    end else begin
                        nxt_timer = dwell_sat;
                    end
                end
                S_SECURITY, S_DATABASE: begin
                    if (level == LVL_GREEN) begin
                        nxt_state = S_COOLDOWN;
                        nxt_ret   = state_q;
                        nxt_timer = '0;
                    end else if (dwell_sat >= ((state_q == S_SECURITY) ? TH_DB : TH_CTRL)) begin
                        nxt_state = (state_q == S_SECURITY) ? S_DATABASE : S_CONTROL;
                        nxt_timer = '0;
                    end else begin
                        nxt_timer = dwell_sat;
                    end
                end
                S_CONTROL: begin
                    if (level == LVL_GREEN) begin
                        nxt_state = S_COOLDOWN;
                        nxt_ret   = S_CONTROL;
                        nxt_timer = '0;
                    end else begin
                        nxt_timer = dwell_sat;
                    end
                end
                S_COOLDOWN: begin
                    if (level == LVL_GREEN) begin
                        if (cool_sat >= TH_COOL) begin
                            nxt_state = S_IDLE;
                            nxt_ret   = S_IDLE;
                            nxt_timer = '0;
                        end else begin
                            nxt_timer = cool_sat;
                        end
                    end else begin
                        nxt_state = ret_q;
                        nxt_timer = '0;
                    end
                end
                default: begin
                    nxt_state = S_IDLE;
                    nxt_ret   = S_IDLE;
                    nxt_timer = '0;
                end
            endcase
        end

        if (cheat_hit) begin
            nxt_state = S_IDLE;
            nxt_ret   = S_IDLE;
            nxt_timer = '0;
        end
    end

    // State, timer and registered outputs; grants follow the next state so
    // they change on the same edge as the transition.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ret_q    <= S_IDLE;
            timer_q  <= '0;
            grants_q <= GRANT_IDLE;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= nxt_state;
            ret_q    <= nxt_ret;
            timer_q  <= nxt_timer;
            grants_q <= grants_of(nxt_state, nxt_ret);
            fault_q  <= ~valid;
        end
    end

    assign a_security    = grants_q[0];
    assign a_database    = grants_q[1];
    assign a_control_sys = grants_q[2];
    assign fault         = fault_q;
    assign state         = state_q;
    assign timer         = timer_q;

endmodule
